// File: rtl/fa_response_checker.sv
// Response checker for the 1-bit full-adder test loop: compares each valid {co,s}
// against a+b+ci and accumulates counts, coverage and a first-failure capture.
module fa_response_checker #(
    parameter int NUM_VEC = 8,
    parameter int CNT_W   = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    input  logic             vld,
    input  logic             a,
    input  logic             b,
    input  logic             ci,
    input  logic             s,
    input  logic             co,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       cov,
    output logic             fail_valid,
    output logic [2:0]       fail_vec,
    output logic [1:0]       fail_got
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] SAT_MAX  = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] vecCnt_q, vecCnt_d;
    logic [CNT_W-1:0] errCnt_q, errCnt_d;
    logic [7:0]       cov_q, cov_d;
    logic             failValid_q, failValid_d;
    logic [2:0]       failVec_q, failVec_d;
    logic [1:0]       failGot_q, failGot_d;
    logic             pass_q, pass_d;

    logic [1:0] expSum;
    logic [1:0] gotSum;
    logic [2:0] vecIdx;
    logic       mismatch;
    logic [7:0] covNext;

    assign expSum   = {1'b0, a} + {1'b0, b} + {1'b0, ci};
    assign gotSum   = {co, s};
    assign vecIdx   = {a, b, ci};
    assign mismatch = (gotSum != expSum);
    assign covNext  = cov_q | (8'd1 << vecIdx);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vecCnt_q    <= '0;
            errCnt_q    <= '0;
            cov_q       <= '0;
            failValid_q <= 1'b0;
            failVec_q   <= '0;
            failGot_q   <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vecCnt_q    <= vecCnt_d;
            errCnt_q    <= errCnt_d;
            cov_q       <= cov_d;
            failValid_q <= failValid_d;
            failVec_q   <= failVec_d;
            failGot_q   <= failGot_d;
            pass_q      <= pass_d;
        end
    end

    // A start that opens a run only clears results; a vld on that same edge is dropped.
    always_comb begin
        state_d     = state_q;
        vecCnt_d    = vecCnt_q;
        errCnt_d    = errCnt_q;
        cov_d       = cov_q;
        failValid_d = failValid_q;
        failVec_d   = failVec_q;
        failGot_d   = failGot_q;
        pass_d      = pass_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    vecCnt_d    = '0;
                    errCnt_d    = '0;
                    cov_d       = '0;
                    failValid_d = 1'b0;
                    failVec_d   = '0;
                    failGot_d   = '0;
                    pass_d      = 1'b0;
                end
            end
            RUN: begin
                if (vld) begin
                    vecCnt_d = vecCnt_q + CNT_W'(1);
                    cov_d    = covNext;
                    if (mismatch && (errCnt_q != SAT_MAX)) begin
                        errCnt_d = errCnt_q + CNT_W'(1);
                    end
                    if (mismatch && !failValid_q) begin
                        failValid_d = 1'b1;
                        failVec_d   = vecIdx;
                        failGot_d   = gotSum;
                    end
                    // Verdict folds in the current vector, which is not yet in the registers.
                    if (vecCnt_q == LAST_IDX) begin
                        state_d = DONE;
                        pass_d  = (errCnt_q == '0) && !mismatch && (covNext == 8'hFF);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign vec_cnt    = vecCnt_q;
    assign err_cnt    = errCnt_q;
    assign cov        = cov_q;
    assign fail_valid = failValid_q;
    assign fail_vec   = failVec_q;
    assign fail_got   = failGot_q;

endmodule
